// File: rtl/pdc_rx.sv
// pdc_rx: oversampling receiver for the PDC link; captures whole frames into a byte buffer.
// Optional per-frame modulo-256 byte checksum is built when PDC_RX_CHECKSUM_EN is defined.
module pdc_rx #(
    parameter int unsigned H_BYTES   = 4,
    parameter int unsigned MAX_BYTES = 4096
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        capture_ON,
    input  logic        VSYNC,
    input  logic        HSYNC,
    input  logic        PIXCLK,
    input  logic [7:0]  PIXD,
    output logic        wr_en,
    output logic [11:0] wr_index,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic [12:0] byte_count,
    output logic [11:0] line_count,
    output logic        overflow,
    output logic        len_err,
    output logic [7:0]  checksum
);

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 12;
    localparam int unsigned CW = 13;
    localparam int unsigned LW = 12;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_FRAME = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;

    // Sync chains: [0] = stage 1, [1] = stage 2, [2] = stage 3 (edge detect)
    logic [2:0]    pclk_sync_q;
    logic [2:0]    vs_sync_q;
    logic [2:0]    hs_sync_q;
    logic [DW-1:0] pixd_s1_q;
    logic [DW-1:0] pixd_s2_q;
    logic [1:0]    prime_q;

    logic          wr_en_q, wr_en_d;
    logic [IW-1:0] wr_index_q, wr_index_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic [CW-1:0] byte_count_q, byte_count_d;
    logic [LW-1:0] line_count_q, line_count_d;
    logic [CW-1:0] line_bytes_q, line_bytes_d;
    logic          overflow_q, overflow_d;
    logic          len_err_q, len_err_d;

    logic          sync_rdy;
    logic          pix_rise;
    logic          v_rise;
    logic          v_fall;
    logic          h_fall;
    logic          byte_accept;
    logic          room;
    logic          wr_take;
    logic          line_end;
    logic [CW-1:0] line_len;

    // Input synchronizers; prime_q masks edges until all three stages hold real samples
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pclk_sync_q <= '0;
            vs_sync_q   <= '0;
            hs_sync_q   <= '0;
            pixd_s1_q   <= '0;
            pixd_s2_q   <= '0;
            prime_q     <= '0;
        end else begin
            pclk_sync_q <= {pclk_sync_q[1:0], PIXCLK};
            vs_sync_q   <= {vs_sync_q[1:0], VSYNC};
            hs_sync_q   <= {hs_sync_q[1:0], HSYNC};
            pixd_s1_q   <= PIXD;
            pixd_s2_q   <= pixd_s1_q;
            prime_q     <= (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
        end
    end

    assign sync_rdy = (prime_q == 2'd3);
    assign pix_rise = sync_rdy &  pclk_sync_q[1] & ~pclk_sync_q[2];
    assign v_rise   = sync_rdy &  vs_sync_q[1]   & ~vs_sync_q[2];
    assign v_fall   = sync_rdy & ~vs_sync_q[1]   &  vs_sync_q[2];
    assign h_fall   = sync_rdy & ~hs_sync_q[1]   &  hs_sync_q[2];

    // A byte coinciding with v_fall still belongs to the frame
    assign byte_accept = (state_q == S_FRAME) & pix_rise & hs_sync_q[1]
                         & (vs_sync_q[1] | v_fall);
    assign room        = (byte_count_q < CW'(MAX_BYTES));
    assign wr_take     = byte_accept & room;
    assign line_end    = (state_q == S_FRAME) & (h_fall | (v_fall & hs_sync_q[1]));
    assign line_len    = (byte_accept && (line_bytes_q != '1)) ? line_bytes_q + CW'(1)
                                                               : line_bytes_q;

    // Next-state and datapath updates
    always_comb begin
        state_d      = state_q;
        wr_en_d      = 1'b0;
        wr_index_d   = wr_index_q;
        wr_data_d    = wr_data_q;
        byte_count_d = byte_count_q;
        line_count_d = line_count_q;
        line_bytes_d = line_bytes_q;
        overflow_d   = overflow_q;
        len_err_d    = len_err_q;

        case (state_q)
            S_IDLE: begin
                if (capture_ON) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                byte_count_d = '0;
                line_count_d = '0;
                line_bytes_d = '0;
                overflow_d   = 1'b0;
                len_err_d    = 1'b0;
                if (!capture_ON) begin
                    state_d = S_IDLE;
                end else if (v_rise) begin
                    state_d = S_FRAME;
                end
            end
            S_FRAME: begin
                if (wr_take) begin
                    wr_en_d      = 1'b1;
                    wr_index_d   = byte_count_q[IW-1:0];
                    wr_data_d    = pixd_s2_q;
                    byte_count_d = byte_count_q + CW'(1);
                end
                if (byte_accept && !room) begin
                    overflow_d = 1'b1;
                end
                line_bytes_d = line_len;
                if (line_end) begin
                    line_count_d = line_count_q + LW'(1);
                    line_bytes_d = '0;
                    if ((H_BYTES != 0) && (line_len != CW'(H_BYTES))) begin
                        len_err_d = 1'b1;
                    end
                end
                if (v_fall) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign frame_done_d = (state_d == S_DONE);
    assign busy_d       = (state_d == S_ARMED) | (state_d == S_FRAME);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q      <= S_IDLE;
            wr_en_q      <= 1'b0;
            wr_index_q   <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            byte_count_q <= '0;
            line_count_q <= '0;
            line_bytes_q <= '0;
            overflow_q   <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            wr_index_q   <= wr_index_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            byte_count_q <= byte_count_d;
            line_count_q <= line_count_d;
            line_bytes_q <= line_bytes_d;
            overflow_q   <= overflow_d;
            len_err_q    <= len_err_d;
        end
    end

`ifdef PDC_RX_CHECKSUM_EN
    logic [DW-1:0] csum_q, csum_d;

    // Sum of written bytes only; dropped bytes never reach the adder
    always_comb begin
        csum_d = csum_q;
        if (state_q == S_ARMED) begin
            csum_d = '0;
        end else if (wr_take) begin
            csum_d = csum_q + pixd_s2_q;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 8'h00;
`endif

    assign wr_en      = wr_en_q;
    assign wr_index   = wr_index_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign byte_count = byte_count_q;
    assign line_count = line_count_q;
    assign overflow   = overflow_q;
    assign len_err    = len_err_q;

endmodule

// File: tb/tb_pdc_rx.sv
// tb_pdc_rx: drives PDC link frames into two receivers (full buffer and 4-byte buffer)
// and compares writes and frame status against a frame-level reference model.
module tb_pdc_rx;

    logic       clk        = 1'b0;
    logic       res_n      = 1'b0;
    logic       capture_ON = 1'b0;
    logic       VSYNC      = 1'b0;
    logic       HSYNC      = 1'b0;
    logic       PIXCLK     = 1'b0;
    logic [7:0] PIXD       = 8'h00;

    logic        d0_wr_en, d0_busy, d0_frame_done, d0_overflow, d0_len_err;
    logic [11:0] d0_wr_index, d0_line_count;
    logic [7:0]  d0_wr_data, d0_checksum;
    logic [12:0] d0_byte_count;
    logic        d1_wr_en, d1_busy, d1_frame_done, d1_overflow, d1_len_err;
    logic [11:0] d1_wr_index, d1_line_count;
    logic [7:0]  d1_wr_data, d1_checksum;
    logic [12:0] d1_byte_count;
    logic [57:0] d0_all, d1_all;

    int checks = 0;
    int errors = 0;

    logic [7:0]  fr_bytes[$];
    int          fr_lens[$];
    logic [19:0] obs0[$];
    logic [19:0] obs1[$];
    int          done_cnt[2]  = '{0, 0};
    int          done_base[2] = '{0, 0};
    logic [12:0] snap_bc[2];
    logic [11:0] snap_lc[2];
    logic        snap_ov[2];
    logic        snap_le[2];
    logic [7:0]  snap_cs[2];

    pdc_rx #(.H_BYTES(4), .MAX_BYTES(4096)) u_dut0 (
        .clk(clk), .res_n(res_n), .capture_ON(capture_ON),
        .VSYNC(VSYNC), .HSYNC(HSYNC), .PIXCLK(PIXCLK), .PIXD(PIXD),
        .wr_en(d0_wr_en), .wr_index(d0_wr_index), .wr_data(d0_wr_data),
        .busy(d0_busy), .frame_done(d0_frame_done), .byte_count(d0_byte_count),
        .line_count(d0_line_count), .overflow(d0_overflow), .len_err(d0_len_err),
        .checksum(d0_checksum)
    );

    pdc_rx #(.H_BYTES(4), .MAX_BYTES(4)) u_dut1 (
        .clk(clk), .res_n(res_n), .capture_ON(capture_ON),
        .VSYNC(VSYNC), .HSYNC(HSYNC), .PIXCLK(PIXCLK), .PIXD(PIXD),
        .wr_en(d1_wr_en), .wr_index(d1_wr_index), .wr_data(d1_wr_data),
        .busy(d1_busy), .frame_done(d1_frame_done), .byte_count(d1_byte_count),
        .line_count(d1_line_count), .overflow(d1_overflow), .len_err(d1_len_err),
        .checksum(d1_checksum)
    );

    assign d0_all = {d0_wr_en, d0_wr_index, d0_wr_data, d0_busy, d0_frame_done,
                     d0_byte_count, d0_line_count, d0_overflow, d0_len_err, d0_checksum};
    assign d1_all = {d1_wr_en, d1_wr_index, d1_wr_data, d1_busy, d1_frame_done,
                     d1_byte_count, d1_line_count, d1_overflow, d1_len_err, d1_checksum};

    always #5 clk = ~clk;

    // Record every write and snapshot status at each frame_done pulse
    always @(negedge clk) begin
        if (d0_wr_en) obs0.push_back({d0_wr_index, d0_wr_data});
        if (d1_wr_en) obs1.push_back({d1_wr_index, d1_wr_data});
        if (d0_frame_done) begin
            done_cnt[0] = done_cnt[0] + 1;
            snap_bc[0] = d0_byte_count; snap_lc[0] = d0_line_count;
            snap_ov[0] = d0_overflow;   snap_le[0] = d0_len_err; snap_cs[0] = d0_checksum;
        end
        if (d1_frame_done) begin
            done_cnt[1] = done_cnt[1] + 1;
            snap_bc[1] = d1_byte_count; snap_lc[1] = d1_line_count;
            snap_ov[1] = d1_overflow;   snap_le[1] = d1_len_err; snap_cs[1] = d1_checksum;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic [7:0] b);
        PIXD = b;
        #40 PIXCLK = 1'b1;
        #40 PIXCLK = 1'b0;
    endtask

    task automatic send_line(input int first, input int n);
        HSYNC = 1'b1;
        #40;
        for (int i = 0; i < n; i++) pix(fr_bytes[first + i]);
        #40 HSYNC = 1'b0;
        #80;
    endtask

    task automatic send_frame(input bit drop_cap);
        int idx;
        idx = 0;
        VSYNC = 1'b1;
        #80;
        for (int l = 0; l < fr_lens.size(); l++) begin
            send_line(idx, fr_lens[l]);
            idx += fr_lens[l];
            if (drop_cap) capture_ON = 1'b0;
        end
        #40 VSYNC = 1'b0;
        #160;
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt[0] > done_base[0] && done_cnt[1] > done_base[1]) break;
            @(negedge clk);
            #1;
        end
        #50;
    endtask

    // Reference: first min(total, depth) bytes land at 0.., status from line lengths
    task automatic check_frame(input string tag);
        for (int d = 0; d < 2; d++) begin
            int          maxb;
            int          total;
            int          nexp;
            logic [19:0] q[$];
            logic [7:0]  sum;
            logic [7:0]  exp_cs;
            logic        exp_le;
            maxb   = (d == 0) ? 4096 : 4;
            total  = fr_bytes.size();
            nexp   = (total < maxb) ? total : maxb;
            sum    = 8'h00;
            exp_le = 1'b0;
            if (d == 0) q = obs0; else q = obs1;
            chk($sformatf("%s d%0d nwrites", tag, d), 64'(q.size()), 64'(nexp));
            for (int i = 0; i < nexp; i++) begin
                sum = sum + fr_bytes[i];
                if (i < q.size())
                    chk($sformatf("%s d%0d write%0d", tag, d, i), 64'(q[i]),
                        64'({12'(i), fr_bytes[i]}));
            end
            foreach (fr_lens[l]) if (fr_lens[l] != 4) exp_le = 1'b1;
`ifdef PDC_RX_CHECKSUM_EN
            exp_cs = sum;
`else
            exp_cs = 8'h00;
`endif
            chk($sformatf("%s d%0d frame_done", tag, d), 64'(done_cnt[d] - done_base[d]), 64'd1);
            chk($sformatf("%s d%0d byte_count", tag, d), 64'(snap_bc[d]), 64'(nexp));
            chk($sformatf("%s d%0d line_count", tag, d), 64'(snap_lc[d]), 64'(fr_lens.size()));
            chk($sformatf("%s d%0d overflow", tag, d), 64'(snap_ov[d]), 64'(total > maxb));
            chk($sformatf("%s d%0d len_err", tag, d), 64'(snap_le[d]), 64'(exp_le));
            chk($sformatf("%s d%0d checksum", tag, d), 64'(snap_cs[d]), 64'(exp_cs));
        end
        obs0.delete();
        obs1.delete();
        done_base[0] = done_cnt[0];
        done_base[1] = done_cnt[1];
    endtask

    task automatic check_nothing(input string tag);
        chk({tag, " d0 nwrites"}, 64'(obs0.size()), 64'd0);
        chk({tag, " d1 nwrites"}, 64'(obs1.size()), 64'd0);
        chk({tag, " d0 frame_done"}, 64'(done_cnt[0] - done_base[0]), 64'd0);
        chk({tag, " d1 frame_done"}, 64'(done_cnt[1] - done_base[1]), 64'd0);
    endtask

    initial begin
        #3;
        #20;
        chk("reset d0 outputs", 64'(d0_all), 64'd0);
        chk("reset d1 outputs", 64'(d1_all), 64'd0);
        res_n = 1'b1;
        #40;
        capture_ON = 1'b1;
        #100;
        chk("armed d0 busy", 64'(d0_busy), 64'd1);
        chk("armed d1 busy", 64'(d1_busy), 64'd1);

        // Single full line
        fr_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        fr_lens  = '{4};
        send_frame(1'b0); wait_frame(); check_frame("line4");

        // Drop capture while armed, then arm in the middle of a frame
        capture_ON = 1'b0;
        #100;
        chk("disarm d0 busy", 64'(d0_busy), 64'd0);
        chk("disarm d1 busy", 64'(d1_busy), 64'd0);
        fr_bytes = '{8'h11, 8'h22};
        VSYNC = 1'b1;
        #80 capture_ON = 1'b1;
        #40;
        send_line(0, 2);
        #40 VSYNC = 1'b0;
        #160;
        check_nothing("skip");
        fr_bytes = '{8'h33, 8'h44, 8'h55, 8'h66};
        fr_lens  = '{4};
        send_frame(1'b0); wait_frame(); check_frame("after_skip");

        fr_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        fr_lens  = '{6};
        send_frame(1'b0); wait_frame(); check_frame("six");

        fr_bytes.delete();
        for (int i = 0; i < 6; i++) fr_bytes.push_back(8'($urandom));
        fr_lens = '{3, 3};
        send_frame(1'b0); wait_frame(); check_frame("two_by_three");

        fr_bytes = '{8'hFF, 8'h02, 8'h80, 8'h7F};
        fr_lens  = '{4};
        send_frame(1'b0); wait_frame(); check_frame("sum00");
        fr_bytes = '{8'hFF, 8'h02};
        fr_lens  = '{2};
        send_frame(1'b0); wait_frame(); check_frame("sum01");

        fr_bytes.delete();
        fr_lens.delete();
        send_frame(1'b0); wait_frame(); check_frame("empty");

        // Frame keeps running after capture_ON drops; results then hold in IDLE
        fr_bytes = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h10, 8'h20, 8'h30, 8'h40};
        fr_lens  = '{4, 4};
        send_frame(1'b1); wait_frame(); check_frame("drop_in_frame");
        #200;
        chk("hold d0 busy", 64'(d0_busy), 64'd0);
        chk("hold d0 byte_count", 64'(d0_byte_count), 64'd8);
        chk("hold d1 byte_count", 64'(d1_byte_count), 64'd4);
        capture_ON = 1'b1;
        #100;

        for (int f = 0; f < 6; f++) begin
            int nl;
            fr_bytes.delete();
            fr_lens.delete();
            nl = int'($urandom_range(1, 3));
            for (int l = 0; l < nl; l++) begin
                int n;
                n = int'($urandom_range(0, 6));
                fr_lens.push_back(n);
                for (int i = 0; i < n; i++) fr_bytes.push_back(8'($urandom));
            end
            send_frame(1'b0); wait_frame(); check_frame($sformatf("rand%0d", f));
        end

        // Reset in the middle of a line: the rest of that frame must be ignored
        fr_bytes = '{8'h91, 8'h92, 8'h93, 8'h94};
        VSYNC = 1'b1;
        #80 HSYNC = 1'b1;
        #40;
        pix(fr_bytes[0]);
        pix(fr_bytes[1]);
        res_n = 1'b0;
        #4;
        chk("midreset d0 outputs", 64'(d0_all), 64'd0);
        chk("midreset d1 outputs", 64'(d1_all), 64'd0);
        obs0.delete();
        obs1.delete();
        done_base[0] = done_cnt[0];
        done_base[1] = done_cnt[1];
        #16 res_n = 1'b1;
        pix(fr_bytes[2]);
        pix(fr_bytes[3]);
        #40 HSYNC = 1'b0;
        #80;
        #40 VSYNC = 1'b0;
        #160;
        check_nothing("post_reset_partial");
        fr_bytes = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        fr_lens  = '{4};
        send_frame(1'b0); wait_frame(); check_frame("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
